// File: rtl/ours_axi32_to_apb_if.sv
// Bus bundle for the single-beat AXI-to-APB4 bridge: the five AXI-style
// request/response channels on one side and one APB4 bus on the other.
// The slave modport is the bridge's view. The master modport is the view of
// whoever drives the requests and plays the APB peripheral.
interface ours_axi32_to_apb_if #(
    parameter int ADDR_W = 32
);
    // write address channel
    logic              awvalid;
    logic              awready;
    logic [11:0]       awid;
    logic [39:0]       awaddr;
    logic [2:0]        awprot;
    // write data channel
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    // read address channel
    logic              arvalid;
    logic              arready;
    logic [11:0]       arid;
    logic [39:0]       araddr;
    logic [2:0]        arprot;
    // read response channel
    logic              rvalid;
    logic              rready;
    logic [11:0]       rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    // write response channel
    logic              bvalid;
    logic              bready;
    logic [11:0]       bid;
    logic [1:0]        bresp;
    // APB4 bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [2:0]        pprot;
    logic              pready;
    logic              pslverr;
    logic [31:0]       prdata;

    modport slave (
        input  awvalid, awid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  arvalid, arid, araddr, arprot,
        input  rready, bready,
        input  pready, pslverr, prdata,
        output awready, wready, arready,
        output rvalid, rid, rdata, rresp, rlast,
        output bvalid, bid, bresp,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport master (
        output awvalid, awid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output arvalid, arid, araddr, arprot,
        output rready, bready,
        output pready, pslverr, prdata,
        input  awready, wready, arready,
        input  rvalid, rid, rdata, rresp, rlast,
        input  bvalid, bid, bresp,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/ours_axi32_to_apb.sv
// Single-beat AXI-to-APB4 bridge. It serves one transaction at a time and
// alternates between reads and writes when both are waiting. Addresses
// outside the window get DECERR without any APB cycle. An APB access that
// stalls too long is cut off with SLVERR.
// ADDR_W must be below 40 so that the window compare has upper bits to test.
module ours_axi32_to_apb #(
    parameter int          ADDR_W    = 32,
    parameter logic [39:0] BASE_ADDR = 40'h0,
    parameter int          TIMEOUT   = 256
) (
    input  logic               clk,
    input  logic               rstn,
    ours_axi32_to_apb_if.slave bus
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The counter only needs to reach TIMEOUT-1. TIMEOUT=0 turns the cut-off off.
    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic             TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP_W,
        RESP_R
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              wr_pend;
    logic              rd_pend;
    logic              grant_wr;
    logic              grant_rd;
    logic              req_hit;
    logic              timeout_hit;

    logic              last_wr_q;
    logic              is_wr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              psel_q;
    logic              penable_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [31:0]       pwdata_q;
    logic [3:0]        pstrb_q;
    logic [2:0]        pprot_q;
    logic              rvalid_q;
    logic              bvalid_q;
    logic [11:0]       rid_q;
    logic [11:0]       bid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        resp_q;

    // An address hits the window when its bits above the APB address match the base.
    function automatic logic win_hit(input logic [39:0] addr);
        return addr[39:ADDR_W] == BASE_ADDR[39:ADDR_W];
    endfunction

    assign wr_pend = bus.awvalid & bus.wvalid;
    assign rd_pend = bus.arvalid;

    // The ready signals come straight from the grant, so they rise only in IDLE.
    assign bus.awready = grant_wr;
    assign bus.wready  = grant_wr;
    assign bus.arready = grant_rd;

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = is_wr_q;
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.pstrb   = pstrb_q;
    assign bus.pprot   = pprot_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = resp_q;
    assign bus.rlast   = 1'b1;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = resp_q;

    // State register for the transaction sequencer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, window decode, APB progress and the timeout decision.
    always_comb begin
        state_d     = state_q;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        req_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_pend && (!rd_pend || !last_wr_q)) begin
                    grant_wr = 1'b1;
                    req_hit  = win_hit(bus.awaddr);
                    state_d  = req_hit ? SETUP : RESP_W;
                end else if (rd_pend) begin
                    grant_rd = 1'b1;
                    req_hit  = win_hit(bus.araddr);
                    state_d  = req_hit ? SETUP : RESP_R;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                timeout_hit = TIMEOUT_EN && !bus.pready && (cnt_q == CNT_LAST);
                if (bus.pready || timeout_hit) begin
                    state_d = is_wr_q ? RESP_W : RESP_R;
                end
            end
            RESP_W: begin
                if (bus.bready) begin
                    state_d = IDLE;
                end
            end
            RESP_R: begin
                if (bus.rready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus control and valids are registered from the next state, so reset clears them at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q <= (state_d == ACCESS);
            rvalid_q  <= (state_d == RESP_R);
            bvalid_q  <= (state_d == RESP_W);
        end
    end

    // Count ACCESS cycles spent waiting for pready, and restart the count outside ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if ((state_q == ACCESS) && (state_d == ACCESS)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Capture the granted request, then the APB result or the error outcome.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_wr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            rid_q     <= '0;
            bid_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            if (grant_wr) begin
                last_wr_q <= 1'b1;
                is_wr_q   <= 1'b1;
                bid_q     <= bus.awid;
                paddr_q   <= bus.awaddr[ADDR_W-1:0];
                pprot_q   <= bus.awprot;
                pwdata_q  <= bus.wdata;
                pstrb_q   <= bus.wstrb;
                if (!req_hit) begin
                    resp_q  <= RESP_DECERR;
                    rdata_q <= '0;
                end
            end else if (grant_rd) begin
                last_wr_q <= 1'b0;
                is_wr_q   <= 1'b0;
                rid_q     <= bus.arid;
                paddr_q   <= bus.araddr[ADDR_W-1:0];
                pprot_q   <= bus.arprot;
                pwdata_q  <= '0;
                pstrb_q   <= '0;
                if (!req_hit) begin
                    resp_q  <= RESP_DECERR;
                    rdata_q <= '0;
                end
            end else if (state_q == ACCESS) begin
                if (bus.pready) begin
                    resp_q <= bus.pslverr ? RESP_SLVERR : RESP_OKAY;
                    if (!is_wr_q) begin
                        rdata_q <= bus.prdata;
                    end
                end else if (timeout_hit) begin
                    resp_q  <= RESP_SLVERR;
                    rdata_q <= '0;
                end
            end
        end
    end

endmodule

// File: doc/ours_axi32_to_apb.md
# ours_axi32_to_apb

Single-beat AXI-to-APB4 bridge that consumes the 32-bit AXI-style request/response channels produced by the oursring 64→32 converter and drives one APB4 peripheral bus. It serialises reads and writes, arbitrates between them round-robin, and decodes an address window. It also bounds slave stall time with a timeout. It sits between the ring converter and low-speed 32-bit peripherals (UART, timers, control registers).

## Interface
- `ADDR_W`, 32: APB `paddr` width; `paddr = addr[ADDR_W-1:0]`.
- `BASE_ADDR`, 40'h0: window base; a hit is `addr[39:ADDR_W] == BASE_ADDR[39:ADDR_W]`.
- `TIMEOUT`, 256: maximum ACCESS cycles without `pready`; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `awvalid`/`awready`  in/out  1  write-address handshake.
- `awid`  in  12  write ID.
- `awaddr`  in  40  write address.
- `awprot`  in  3  protection, forwarded to `pprot`.
- `wvalid`/`wready`  in/out  1  write-data handshake.
- `wdata`  in  32  write data.
- `wstrb`  in  4  byte strobes.
- `arvalid`/`arready`  in/out  1  read-address handshake.
- `arid`  in  12  read ID.
- `araddr`  in  40  read address.
- `arprot`  in  3  protection, forwarded to `pprot`.
- `rvalid`/`rready`  out/in  1  read-response handshake.
- `rid`  out  12  read ID.
- `rdata`  out  32  read data.
- `rresp`  out  2  read response.
- `rlast`  out  1  last beat; always 1.
- `bvalid`/`bready`  out/in  1  write-response handshake.
- `bid`  out  12  write ID.
- `bresp`  out  2  write response.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  32  APB write data.
- `pstrb`  out  4  APB strobes.
- `pprot`  out  3  APB protection.
- `pready`, `pslverr`  in  1  APB completion and error.
- `prdata`  in  32  APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP_W, RESP_R.
- IDLE: a write is pending when `awvalid & wvalid`; a read is pending when `arvalid`.
  - If both are pending, grant the type opposite to the last granted one (`last_wr` flag, reset 0, so a write wins first).
  - The grant asserts `awready`+`wready` together, or `arready`, combinationally in IDLE only.
  - On the grant, capture id, addr, prot, wdata and wstrb, and set `is_wr`.
- Window hit → SETUP. Miss → response state directly with resp=DECERR (2'b11); no APB cycle.
- SETUP: `psel=1`, `penable=0`. Always one cycle, then ACCESS.
- ACCESS: `psel=1`, `penable=1`; hold all APB outputs stable.
  - On `pready`, capture `prdata` (reads) and resp = `pslverr` ? SLVERR (2'b10) : OKAY (2'b00), then go to RESP_W or RESP_R.
  - Timeout: a counter increments for each ACCESS cycle without `pready`. When the count reaches TIMEOUT-1 and `pready=0`, go to the response state with SLVERR and `rdata=0`.
  - `pready` in the same cycle as the timeout: `pready` wins.
- RESP_W: `bvalid=1` until `bready`; then IDLE.
- RESP_R: `rvalid=1`, `rlast=1` until `rready`; then IDLE.
- `rdata` is 0 on DECERR and on timeout.
- `pwrite=is_wr`; `pstrb=wstrb` for writes, 0 for reads. `pwdata=0` for reads.
- Exactly one transaction is outstanding at a time.
- Reset values: all valid/ready outputs, `psel`, `penable`, `pwrite` are 0; `paddr`, `pwdata`, `pstrb`, `pprot` are 0; `rid`/`bid`/`rdata`/resp are 0; counter 0; `last_wr` 0; state IDLE.
- Reset asserted mid-operation: APB outputs and response valids drop immediately (asynchronously); the in-flight transaction is discarded.

## Timing
- Grant at cycle T → SETUP at T+1 → ACCESS at T+2.
- `pready` at T+2+k → response valid at T+3+k. All APB and response outputs are registered.
- Response handshake at cycle R → IDLE at R+1; the next grant is possible at R+1.
  - Minimum 4 cycles per transaction with zero wait states and no response backpressure.
- DECERR: grant at T → response valid at T+1.
- Timeout: with `pready` held low, the response valid is at T+2+TIMEOUT, and `psel` drops in the same cycle.
- Request `valid` may drop before grant without effect; after the grant, request inputs are don't-care.

## Test plan
- Write 0xDEADBEEF, wstrb 4'hF, awid 0x12 to an in-window address; slave `pready` immediate → one SETUP then one ACCESS with `pwrite=1`, `pstrb=F`; `bvalid` at T+3 with bid 0x12, bresp 00.
- Read with 3 wait states, `prdata=0xCAFE0001`, `pslverr=1` → `rvalid` at T+6, rdata 0xCAFE0001, rresp 10, rlast 1; `rready` low for 2 cycles → response held stable.
- Write and read both pending from reset for 4 transactions → grant order W, R, W, R; `awready`/`wready` never asserted in the same cycle as `arready`.
- `araddr` outside the window → no `psel`; `rvalid` at T+1 with rresp 11, rdata 0.
- TIMEOUT=4, `pready` stuck low → exactly 4 ACCESS cycles, then SLVERR response and `psel` low; a second test asserts `pready` on the 4th cycle → OKAY.
- Assert `rstn` low during ACCESS → `psel`/`penable` go 0 immediately; after release the bridge is in IDLE and the next write completes normally.
